// File: rtl/dfswt_bank.sv
// Sliding-sign DFT bin bank: one frame of POINTS samples is correlated against
// square-wave cos/sin references for bins 1..NBINS. When a frame closes, its
// sums are copied into a result bank, and one magnitude per bin is then drained.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | result bank empty, out_valid low
// ST_DRAIN | result bank holds a frame, presenting bin bin_q
module dfswt_bank #(
  parameter int DW    = 16,
  parameter int LOG2P = 3,
  parameter int NBINS = 4,
  parameter int SHIFT = 0,
  localparam int POINTS = 2 ** LOG2P,
  localparam int ACC_W  = DW + LOG2P + 1,
  localparam int MAG_W  = 2 * (ACC_W - SHIFT),
  localparam int BW     = $clog2(NBINS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW-1:0]        out_bin,
  output logic [MAG_W-1:0]     out_mag,
  output logic                 out_last
);

  localparam int SW = ACC_W - SHIFT;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           bin_q, bin_d;
  logic [LOG2P-1:0]        idx_q, idx_d;
  logic [LOG2P-1:0]        px_q [NBINS];
  logic [LOG2P-1:0]        px_d [NBINS];
  logic [LOG2P-1:0]        py_q [NBINS];
  logic [LOG2P-1:0]        py_d [NBINS];
  logic signed [ACC_W-1:0] ax_q [NBINS];
  logic signed [ACC_W-1:0] ax_d [NBINS];
  logic signed [ACC_W-1:0] ay_q [NBINS];
  logic signed [ACC_W-1:0] ay_d [NBINS];
  logic signed [ACC_W-1:0] bx_q [NBINS];
  logic signed [ACC_W-1:0] bx_d [NBINS];
  logic signed [ACC_W-1:0] by_q [NBINS];
  logic signed [ACC_W-1:0] by_d [NBINS];
  logic signed [ACC_W-1:0] ax_nx [NBINS];
  logic signed [ACC_W-1:0] ay_nx [NBINS];

  logic                    accept, close, out_fire;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sel_x, sel_y;
  logic signed [SW-1:0]    sx, sy;
  logic signed [MAG_W-1:0] sx_ext, sy_ext, sq_x, sq_y;

  assign din_ext   = ACC_W'(in_data);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid && (bin_q == BW'(NBINS));
  assign out_bin   = bin_q;
  assign out_fire  = out_valid && out_ready;
  // The closing sample must wait while the bank is still occupied, except when
  // the last bin leaves on the very edge the new frame closes.
  assign in_ready  = !((idx_q == '1) && (state_q == ST_DRAIN)) || (out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (idx_q == '1);

  // Per-bin signed update of both accumulators from their phase MSBs.
  always_comb begin
    for (int i = 0; i < NBINS; i++) begin
      ax_nx[i] = px_q[i][LOG2P-1] ? (ax_q[i] - din_ext) : (ax_q[i] + din_ext);
      ay_nx[i] = py_q[i][LOG2P-1] ? (ay_q[i] - din_ext) : (ay_q[i] + din_ext);
    end
  end

  // Frame datapath: advance on accepted samples, bank and rewind on close.
  always_comb begin
    idx_d = idx_q;
    for (int i = 0; i < NBINS; i++) begin
      px_d[i] = px_q[i];
      py_d[i] = py_q[i];
      ax_d[i] = ax_q[i];
      ay_d[i] = ay_q[i];
      bx_d[i] = bx_q[i];
      by_d[i] = by_q[i];
    end
    if (accept) begin
      idx_d = idx_q + 1'b1;
      for (int i = 0; i < NBINS; i++) begin
        if (close) begin
          bx_d[i] = ax_nx[i];
          by_d[i] = ay_nx[i];
          ax_d[i] = '0;
          ay_d[i] = '0;
          px_d[i] = LOG2P'(POINTS / 4);
          py_d[i] = '0;
        end else begin
          ax_d[i] = ax_nx[i];
          ay_d[i] = ay_nx[i];
          px_d[i] = px_q[i] + LOG2P'(i + 1);
          py_d[i] = py_q[i] + LOG2P'(i + 1);
        end
      end
    end
  end

  // Output FSM: a close always restarts the drain at bin 1, even when it
  // coincides with the final handshake of the previous frame.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    if (close) begin
      state_d = ST_DRAIN;
      bin_d   = BW'(1);
    end else if (out_fire) begin
      if (out_last) begin
        state_d = ST_IDLE;
        bin_d   = BW'(1);
      end else begin
        bin_d = bin_q + 1'b1;
      end
    end
  end

  // Magnitude of the presented bin from the banked sums.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NBINS; i++) begin
      if (bin_q == BW'(i + 1)) begin
        sel_x = bx_q[i];
        sel_y = by_q[i];
      end
    end
    sx      = sel_x[ACC_W-1:SHIFT];
    sy      = sel_y[ACC_W-1:SHIFT];
    sx_ext  = MAG_W'(sx);
    sy_ext  = MAG_W'(sy);
    sq_x    = sx_ext * sx_ext;
    sq_y    = sy_ext * sy_ext;
    out_mag = $unsigned(sq_x + sq_y);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= BW'(1);
      idx_q   <= '0;
      for (int i = 0; i < NBINS; i++) begin
        px_q[i] <= LOG2P'(POINTS / 4);
        py_q[i] <= '0;
        ax_q[i] <= '0;
        ay_q[i] <= '0;
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NBINS; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
        ax_q[i] <= ax_d[i];
        ay_q[i] <= ay_d[i];
        bx_q[i] <= bx_d[i];
        by_q[i] <= by_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dfswt_bank.sv
// Bench for dfswt_bank: a frame-level DFT-sign model predicts every result and
// the ready/valid behaviour, and is compared against the DUT on each falling edge.
module tb_dfswt_bank;
  localparam int DW = 16, LOG2P = 3, NBINS = 4, SHIFT = 0;
  localparam int P = 8, MAG_W = 40, BW = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [BW-1:0]        out_bin;
  logic [MAG_W-1:0]     out_mag;
  logic                 out_last;

  dfswt_bank #(.DW(DW), .LOG2P(LOG2P), .NBINS(NBINS), .SHIFT(SHIFT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_mag(out_mag), .out_last(out_last)
  );

  always #5 clock = ~clock;

  typedef struct {int bin; longint mag; bit last;} res_t;

  int     checks = 0;
  int     passes = 0;
  int     frame_q[$];
  res_t   exp_q[$];
  longint got_mag [1:4];
  int     got_cnt = 0;
  bit     same_edge_seen = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  function automatic int sgn(input int ph);
    return (ph >= P / 2) ? -1 : 1;
  endfunction

  // Square-wave DFT of one full frame for every bin.
  task automatic model_frame();
    for (int k = 1; k <= NBINS; k++) begin
      longint x = 0, y = 0;
      res_t r;
      for (int n = 0; n < P; n++) begin
        x += frame_q[n] * sgn((P / 4 + n * k) % P);
        y += frame_q[n] * sgn((n * k) % P);
      end
      r.bin  = k;
      r.mag  = x * x + y * y;
      r.last = (k == NBINS);
      exp_q.push_back(r);
    end
    frame_q.delete();
  endtask

  task automatic clear_got();
    for (int k = 1; k <= 4; k++) got_mag[k] = -1;
    got_cnt = 0;
  endtask

  // Compare process: every cycle, DUT versus model, then advance the model.
  always @(negedge clock) begin
    if (!reset) begin
      frame_q.delete();
      exp_q.delete();
    end else begin
      bit exp_rdy;
      exp_rdy = !((frame_q.size() == P - 1) && (exp_q.size() > 0)) ||
                ((exp_q.size() == 1) && out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0 && out_valid) begin
        chk("out_bin", out_bin, exp_q[0].bin);
        chk("out_mag", out_mag, exp_q[0].mag);
        chk("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          if (out_bin >= 1 && out_bin <= 4) got_mag[out_bin] = longint'(out_mag);
          got_cnt++;
          if (out_last && in_valid && in_ready) same_edge_seen = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        frame_q.push_back(int'(in_data));
        if (frame_q.size() == P) model_frame();
      end
    end
  end

  task automatic send(input int s);
    bit acc;
    in_valid = 1'b1;
    in_data  = DW'(s);
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      acc = in_ready && reset;
      @(posedge clock);
      #1;
      if (acc) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit nyq, input int gap);
    for (int n = 0; n < P; n++) begin
      send(nyq ? ((n % 2) ? -100 : 100) : 100);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (!out_valid && exp_q.size() == 0) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic check_nyquist(input string tag);
    chk({tag, "_count"}, got_cnt, 4);
    chk({tag, "_bin1"}, got_mag[1], 0);
    chk({tag, "_bin2"}, got_mag[2], 0);
    chk({tag, "_bin3"}, got_mag[3], 0);
    chk({tag, "_bin4"}, got_mag[4], 1280000);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);

    // DC frame
    out_ready = 1'b1;
    clear_got();
    send_frame(1'b0, 0);
    wait_idle();
    chk("dc_count", got_cnt, 4);
    for (int k = 1; k <= 4; k++) chk("dc_mag", got_mag[k], 0);

    // Nyquist frame
    clear_got();
    send_frame(1'b1, 0);
    wait_idle();
    check_nyquist("nyq");

    // Backpressure: DC frame held in the bank while a Nyquist frame streams
    clear_got();
    out_ready = 1'b0;
    send_frame(1'b0, 0);
    same_edge_seen = 1'b0;
    fork
      send_frame(1'b1, 0);
      begin
        repeat (15) @(posedge clock);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_bin_held", out_bin, 1);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_same_edge", same_edge_seen, 1);
    chk("bp_count", got_cnt, 8);
    chk("bp_bin4", got_mag[4], 1280000);

    // Toggled out_ready during drain
    clear_got();
    out_ready = 1'b0;
    send_frame(1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      out_ready = ~out_ready;
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();
    check_nyquist("stall");

    // Reset mid-drain discards pending results
    out_ready = 1'b0;
    send_frame(1'b1, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_drain_valid", out_valid, 0);
    chk("rst_drain_bin", out_bin, 1);

    // Reset after 5 samples, then a clean Nyquist frame
    for (int n = 0; n < 5; n++) send(n * 37 + 11);
    in_valid = 1'b1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_valid", out_valid, 0);
    clear_got();
    send_frame(1'b1, 0);
    wait_idle();
    check_nyquist("rstmid");

    // in_valid gaps
    clear_got();
    send_frame(1'b1, 2);
    wait_idle();
    check_nyquist("gaps");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
